imu_slerp_request_gen: RTL and testbench

- Producer side of the SLERP interpolation path in the IMU synchronizer.
- Buffers timestamped IMU quaternion samples and accepts target timestamps, e.g. camera frame times.
- For each target, finds the bracketing sample pair and computes the Q16 interpolation fraction t with an iterative divider.
- Issues {t, q1, q2} over a valid/ready handshake to the interpolation stage.

---
 rtl/imu_slerp_request_gen.sv | 165 ++++++++++++++++
 tb/tb_imu_slerp_request_gen.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imu_slerp_request_gen.sv
// Buffers timestamped IMU quaternions and, per target time, issues the bracketing pair
// plus a Q16 fraction. Define IMU_SYNC_DROP_CNT_EN to add the drop_cnt output.
module imu_slerp_request_gen #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            imu_valid,
  output logic            imu_ready,
  input  logic [TS_W-1:0] imu_ts,
  input  logic [127:0]    imu_q,
  input  logic            tgt_valid,
  output logic            tgt_ready,
  input  logic [TS_W-1:0] tgt_ts,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [31:0]     req_t,
  output logic [127:0]    req_q1,
  output logic [127:0]    req_q2,
  output logic            req_stale,
  output logic            err_nonmono
`ifdef IMU_SYNC_DROP_CNT_EN
  ,
  output logic [15:0]     drop_cnt
`endif
);

  // valid/ready: a transfer happens on a rising clk edge where both are high; a producer
  // holding valid keeps its payload stable until that edge.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DIVIDE, S_OUTPUT} state_t;
  state_t state, state_nx;

  logic [TS_W-1:0] ts_mem [DEPTH];
  logic [127:0]    q_mem  [DEPTH];
  logic [AW-1:0]   head, head_nx1, tail, newest;
  logic [CW-1:0]   count;
  logic [TS_W-1:0] tgt_lat, ts1, ts2, den;
  logic [TS_W:0]   rem, rem_sh;
  logic [14:0]     quo;
  logic [3:0]      bit_cnt;
  logic            q_bit, imu_acc, drop, push, pop, have2, tgt_lt, tgt_ge;

  assign head_nx1  = head + AW'(1);
  assign tail      = head + count[AW-1:0];
  assign newest    = tail - AW'(1);
  assign ts1       = ts_mem[head];
  assign ts2       = ts_mem[head_nx1];
  assign imu_ready = (count != CW'(DEPTH));
  assign imu_acc   = imu_valid && imu_ready;
  assign drop      = imu_acc && (count != '0) && (imu_ts <= ts_mem[newest]);
  assign push      = imu_acc && !drop;
  assign have2     = (count >= CW'(2));
  assign tgt_lt    = (tgt_lat < ts1);
  assign tgt_ge    = (tgt_lat >= ts2);
  // Restoring divider step: remainder stays below den, so the doubled value fits TS_W+1 bits.
  assign rem_sh    = rem << 1;
  assign q_bit     = (rem_sh >= {1'b0, den});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (tgt_valid) state_nx = S_SEARCH;
      S_SEARCH: begin
        if (have2) begin
          if (tgt_lt)       state_nx = S_OUTPUT;
          else if (!tgt_ge) state_nx = S_DIVIDE;
        end
      end
      S_DIVIDE: if (bit_cnt == 4'd15) state_nx = S_OUTPUT;
      S_OUTPUT: if (req_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    tgt_ready = 1'b0;
    req_valid = 1'b0;
    pop       = 1'b0;
    case (state)
      S_IDLE:   tgt_ready = 1'b1;
      S_SEARCH: pop = have2 && !tgt_lt && tgt_ge && (count > CW'(2));
      S_OUTPUT: req_valid = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ts_mem[tail] <= imu_ts;
      q_mem[tail]  <= imu_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head        <= '0;
      count       <= '0;
      err_nonmono <= 1'b0;
    end else begin
      if (pop) head <= head_nx1;
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (drop) err_nonmono <= 1'b1;
    end
  end

  // Request payload is only written in SEARCH/DIVIDE, so it holds steady throughout OUTPUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tgt_lat   <= '0;
      den       <= '0;
      rem       <= '0;
      quo       <= '0;
      bit_cnt   <= '0;
      req_t     <= '0;
      req_q1    <= '0;
      req_q2    <= '0;
      req_stale <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (tgt_valid) tgt_lat <= tgt_ts;
        S_SEARCH: begin
          if (have2 && tgt_lt) begin
            req_q1    <= q_mem[head];
            req_q2    <= q_mem[head];
            req_t     <= '0;
            req_stale <= 1'b1;
          end else if (have2 && !tgt_ge) begin
            req_q1    <= q_mem[head];
            req_q2    <= q_mem[head_nx1];
            rem       <= {1'b0, tgt_lat - ts1};
            den       <= ts2 - ts1;
            quo       <= '0;
            bit_cnt   <= '0;
            req_stale <= 1'b0;
          end
        end
        S_DIVIDE: begin
          rem     <= q_bit ? (rem_sh - {1'b0, den}) : rem_sh;
          quo     <= {quo[13:0], q_bit};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) req_t <= {16'd0, quo, q_bit};
        end
        default: ;
      endcase
    end
  end

`ifdef IMU_SYNC_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF)  drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_imu_slerp_request_gen.sv
// Bench for imu_slerp_request_gen: directed cases then randomized samples/targets,
// checked against a queue-based bracketing/fraction model.
module tb_imu_slerp_request_gen;
  localparam int DEPTH = 8;
  localparam int TS_W  = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            imu_valid = 1'b0, imu_ready;
  logic [TS_W-1:0] imu_ts = '0;
  logic [127:0]    imu_q = '0;
  logic            tgt_valid = 1'b0, tgt_ready;
  logic [TS_W-1:0] tgt_ts = '0;
  logic            req_valid, req_ready = 1'b0;
  logic [31:0]     req_t;
  logic [127:0]    req_q1, req_q2;
  logic            req_stale, err_nonmono;
`ifdef IMU_SYNC_DROP_CNT_EN
  logic [15:0]     drop_cnt;
`endif

  imu_slerp_request_gen #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .imu_valid(imu_valid), .imu_ready(imu_ready), .imu_ts(imu_ts), .imu_q(imu_q),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt_ts(tgt_ts),
    .req_valid(req_valid), .req_ready(req_ready), .req_t(req_t),
    .req_q1(req_q1), .req_q2(req_q2), .req_stale(req_stale),
    .err_nonmono(err_nonmono)
`ifdef IMU_SYNC_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  ts;
    logic [127:0] q;
  } samp_t;

  samp_t       mq[$];
  logic [31:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          m_drops = 0;
  logic        m_err = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand_q();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Model: store a sample unless the buffer is full; drop it if it is not newer than the newest.
  task automatic m_push(input logic [31:0] ts, input logic [127:0] q);
    samp_t s;
    if (mq.size() == DEPTH) return;
    if (mq.size() > 0 && ts <= mq[$].ts) begin
      m_err = 1'b1;
      if (m_drops < 65535) m_drops++;
    end else begin
      s.ts = ts;
      s.q  = q;
      mq.push_back(s);
    end
  endtask

  // Model: discard samples the target has passed, then bracket and compute floor(frac * 2^16).
  task automatic m_target(input logic [31:0] tgt, output logic [127:0] e_q1,
                          output logic [127:0] e_q2, output logic e_stale, output int e_lat);
    int pops = 0;
    logic [63:0] num, den;
    while (mq.size() > 2 && tgt >= mq[1].ts) begin
      void'(mq.pop_front());
      pops++;
    end
    if (tgt < mq[0].ts) begin
      exp_q.push_back(32'd0);
      e_q1 = mq[0].q; e_q2 = mq[0].q; e_stale = 1'b1; e_lat = 1 + pops;
    end else begin
      num = 64'(tgt - mq[0].ts) << 16;
      den = 64'(mq[1].ts - mq[0].ts);
      exp_q.push_back(32'(num / den));
      e_q1 = mq[0].q; e_q2 = mq[1].q; e_stale = 1'b0; e_lat = 17 + pops;
    end
  endtask

  task automatic push(input logic [31:0] ts, input logic [127:0] q);
    logic rdy;
    imu_valid = 1'b1; imu_ts = ts; imu_q = q;
    rdy = imu_ready;
    @(negedge clk);
    imu_valid = 1'b0;
    if (rdy) m_push(ts, q);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imu_valid = 1'b0; tgt_valid = 1'b0; req_ready = 1'b0;
    #1;
    chk("rst_imu_ready", imu_ready, 1'b1);
    chk("rst_tgt_ready", tgt_ready, 1'b1);
    chk("rst_req_valid", req_valid, 1'b0);
    chk("rst_req_t", req_t, 32'd0);
    chk("rst_req_q1", req_q1, 128'd0);
    chk("rst_req_q2", req_q2, 128'd0);
    chk("rst_req_stale", req_stale, 1'b0);
    chk("rst_err_nonmono", err_nonmono, 1'b0);
`ifdef IMU_SYNC_DROP_CNT_EN
    chk("rst_drop_cnt", drop_cnt, 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete(); exp_q.delete();
    m_err = 1'b0; m_drops = 0;
    @(negedge clk);
  endtask

  // Checks the presented request, holds it for `hold` cycles, then completes the handshake.
  task automatic check_req(input string tag, input logic [127:0] e_q1, input logic [127:0] e_q2,
                           input logic e_stale, input int hold);
    logic [31:0] e_t;
    e_t = exp_q.pop_front();
    chk({tag, "_valid"}, req_valid, 1'b1);
    chk({tag, "_t"}, req_t, e_t);
    chk({tag, "_q1"}, req_q1, e_q1);
    chk({tag, "_q2"}, req_q2, e_q2);
    chk({tag, "_stale"}, req_stale, e_stale);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, req_valid, 1'b1);
      chk({tag, "_hold_tgt_ready"}, tgt_ready, 1'b0);
      chk({tag, "_hold_t"}, req_t, e_t);
      chk({tag, "_hold_q1"}, req_q1, e_q1);
      chk({tag, "_hold_q2"}, req_q2, e_q2);
    end
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    chk({tag, "_done_valid"}, req_valid, 1'b0);
    chk({tag, "_done_tgt_ready"}, tgt_ready, 1'b1);
  endtask

  task automatic run_target(input string tag, input logic [31:0] tgt, input int hold);
    logic [127:0] e_q1, e_q2;
    logic e_stale;
    int e_lat, lat;
    m_target(tgt, e_q1, e_q2, e_stale, e_lat);
    chk({tag, "_tgt_ready"}, tgt_ready, 1'b1);
    tgt_valid = 1'b1; tgt_ts = tgt;
    @(negedge clk);
    tgt_valid = 1'b0;
    lat = 0;
    while (!req_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, e_lat);
    check_req(tag, e_q1, e_q2, e_stale, hold);
  endtask

  initial begin
    logic [127:0] qa, qb, qc, e_q1, e_q2;
    logic e_stale;
    int e_lat, w;
    logic [31:0] last_tgt, newest, ts, tgt;

    qa = {32'd0, 32'd0, 32'd0, 32'h0001_0000};
    qb = {32'd0, 32'd0, 32'h0001_0000, 32'd0};
    qc = rand_q();
    @(negedge clk);
    do_reset();

    // Basic bracket, fractions, pop on advancing target.
    push(1000, qa);
    push(2000, qb);
    run_target("t1250", 1250, 0);
    run_target("t1500", 1500, 10);
    run_target("t1999", 1999, 1);
    push(3000, qc);
    run_target("t2500_pop", 2500, 0);
    run_target("t2750", 2750, 2);

    // Stale target, then a target past the newest sample that must wait for data.
    do_reset();
    push(1000, qa);
    push(2000, qb);
    run_target("stale500", 500, 3);
    tgt_valid = 1'b1; tgt_ts = 2500;
    @(negedge clk);
    tgt_valid = 1'b0;
    w = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (req_valid) w++;
    end
    chk("wait_no_req", w, 0);
    push(3000, qc);
    m_target(2500, e_q1, e_q2, e_stale, e_lat);
    w = 0;
    while (!req_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("wait_timeout", (w < 200), 1'b1);
    check_req("wait_req", e_q1, e_q2, e_stale, 1);

    // Non-monotonic drop, fill to full, push while full, then reset mid-divide.
    do_reset();
    push(2000, rand_q());
    push(1500, rand_q());
    chk("drop_err", err_nonmono, m_err);
`ifdef IMU_SYNC_DROP_CNT_EN
    chk("drop_cnt", drop_cnt, 16'(m_drops));
`endif
    for (int i = 1; i < DEPTH; i++) begin
      chk("fill_ready", imu_ready, 1'b1);
      push(2000 + 1000 * i, rand_q());
    end
    chk("full_ready", imu_ready, (mq.size() != DEPTH));
    push(20000, rand_q());
    chk("full_still", imu_ready, (mq.size() != DEPTH));
    tgt_valid = 1'b1; tgt_ts = 2500;
    @(negedge clk);
    tgt_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("middiv_busy", tgt_ready, 1'b0);
    #2;
    do_reset();

    // Randomized samples and nondecreasing targets.
    push(1000 + $urandom_range(0, 500), rand_q());
    push(mq[$].ts + $urandom_range(1, 3000), rand_q());
    last_tgt = mq[0].ts - 300;
    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
        newest = mq[$].ts;
        if ($urandom_range(0, 4) == 0) ts = newest - $urandom_range(0, 50);
        else ts = newest + $urandom_range(1, 3000);
        push(ts, rand_q());
        chk("rnd_err", err_nonmono, m_err);
`ifdef IMU_SYNC_DROP_CNT_EN
        chk("rnd_drop_cnt", drop_cnt, 16'(m_drops));
`endif
      end
      chk("rnd_imu_ready", imu_ready, (mq.size() != DEPTH));
      for (int k = 0; k < int'($urandom_range(1, 2)); k++) begin
        newest = mq[$].ts;
        if (newest - 1 >= last_tgt) begin
          tgt = last_tgt + $urandom_range(0, newest - 1 - last_tgt);
          run_target("rnd", tgt, $urandom_range(0, 3));
          last_tgt = tgt;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
